param_counter: RTL
==================

Name: param_counter

Overview:
- Parametrised successor to the team's free-running 8-bit counter.
- Adds the following, all in one clock domain:
  - configurable width
  - programmable modulo limit
  - up/down direction
  - synchronous load
  - clock-enable prescaler
  - wrap or saturate mode
  - terminal-count pulse and sticky overflow flag
- Used as a general timebase and event counter in the FPGA demo designs and drives LEDs and debug buses.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- PRESCALE, 1: number of enabled clocks per count step; 1 means a step on every enabled clock; legal range 1..65535.
- SATURATE, 0: 0 means wrap at the limits, 1 means hold at the limit.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; when low, both prescaler and counter hold.
- up_dn  in  1  1 counts up, 0 counts down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value taken by count on load.
- max_val  in  WIDTH  inclusive upper limit of the count range 0..max_val.
- ovf_clr  in  1  clears the sticky ovf flag.
- count  out  WIDTH  current count, registered.
- tc  out  1  one-cycle pulse, registered, coincident with count taking its boundary-crossing value.
- ovf  out  1  sticky flag, set on any boundary event.

Behaviour:
- Reset:
  - All state updates on the rising edge of clk. rst is synchronous and active-high.
  - On reset: count=0, tc=0, ovf=0, prescaler=0.
  - Reset overrides every other input in the same cycle.
- Priority: rst > load > step > hold.
- Load:
  - count <= load_val, prescaler <= 0, tc <= 0. The ovf flag is unaffected.
  - load_val is not range-checked against max_val.
- Prescaler:
  - Internal counter runs 0..PRESCALE-1 and advances only when en=1.
  - step = en && (prescaler == PRESCALE-1); the prescaler then returns to 0.
  - With PRESCALE=1, step = en.
- Up step:
  - If count >= max_val (boundary):
    - SATURATE=0: count <= 0.
    - SATURATE=1: count <= max_val.
    - In both cases tc <= 1 and ovf <= 1.
  - Otherwise count <= count+1 and tc <= 0.
  - A count above max_val (after a load or a max_val change) is treated as a boundary.
- Down step:
  - If count == 0 (boundary):
    - SATURATE=0: count <= max_val.
    - SATURATE=1: count stays 0.
    - In both cases tc <= 1 and ovf <= 1.
  - Otherwise count <= count-1, including when count > max_val.
- Saturate mode: tc and ovf pulse on every step taken while held at the limit, so tc repeats every PRESCALE enabled cycles.
- No step (hold): count holds and tc <= 0.
- tc is high for exactly one cycle per boundary step and is never high two cycles in a row when PRESCALE > 1.
- ovf flag:
  - ovf_clr=1 clears ovf.
  - If a boundary step occurs in the same cycle as ovf_clr, set wins and ovf stays 1.
- Arithmetic: all arithmetic is WIDTH bits wide with no intermediate overflow. max_val = 2^WIDTH-1 gives full natural wrap.
- Combined cases:
  - up_dn may change on any cycle and takes effect at the next step.
  - With max_val=0 and SATURATE=0, every step is a boundary: count stays 0 and tc pulses on each step.
- Latency: one clock from a qualifying input to the count, tc and ovf outputs. There are no combinational input-to-output paths.

Decomposition:
- Package param_counter_pkg:
  - localparam constants MODE_WRAP=0 and MODE_SAT=1.
  - Function clog2 for sizing the prescaler width: max(1, clog2(PRESCALE)).
- Sub-module tick_gen (parameter PRESCALE):
  - Inputs: clk, rst, en, clr.
  - Output: step, a combinational strobe from registered state.
  - clr is driven by load.
- The top module holds the count register, boundary logic, tc and ovf.

Test Plan:
- Reset and free-run: WIDTH=8, PRESCALE=1, max_val=255, up, en=1, rst held 2 cycles then released. Required:
  - count=0 during reset.
  - count=255 after 255 enabled cycles.
  - On the next cycle count=0 with tc=1 for one cycle and ovf=1.
- Modulo and down wrap: max_val=9, down, starting from load_val=2. Required:
  - Sequence 2,1,0,9,8.
  - tc high only on the cycle count becomes 9.
- Saturate: SATURATE=1, max_val=5, up from 3. Required:
  - Sequence 3,4,5,5,5.
  - tc pulses on each step at 5.
  - ovf=1.
  - ovf_clr pulse with no concurrent step leaves ovf=0.
  - ovf_clr asserted in the same cycle as a boundary step leaves ovf=1.
- Prescaler and enable: PRESCALE=4, en toggling (1,1,0,1,1). Required:
  - First step on the 4th enabled cycle, count 0->1.
  - en=0 cycles do not advance the prescaler.
- Priority: load=1 with load_val=0x3C in the same cycle as a boundary step. Required:
  - count=0x3C, tc=0, ovf unchanged.
  - rst asserted together with load gives count=0.
- Out-of-range: load 20 with max_val=10. Required:
  - Up step gives count=0 with tc=1.
  - Repeat the load, then a down step gives count=19.

Source files
------------

// File: rtl/param_counter_pkg.sv
// Shared constants and sizing helper for the parametrised counter.
package param_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/param_counter_tick.sv
// Prescaler: emits a step strobe once every PRESCALE enabled clocks.
module tick_gen
  import param_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  // With PRESCALE=1 LAST is 0, so presc never leaves 0 and step follows en.
  assign step = en && (presc == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == LAST) ? '0 : presc + PW'(1);
    end
  end

endmodule

// File: rtl/param_counter.sv
// Modulo up/down counter with load, prescaled steps, wrap or saturate,
// terminal-count pulse and sticky overflow flag.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic             step;
  logic             boundary_hit;
  logic [WIDTH-1:0] count_nxt;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (step)
  );

  // A count above max_val counts as a boundary going up, but steps down normally.
  always_comb begin
    count_nxt    = count;
    boundary_hit = 1'b0;
    if (load) begin
      count_nxt = load_val;
    end else if (step) begin
      if (up_dn) begin
        if (count >= max_val) begin
          boundary_hit = 1'b1;
          count_nxt    = (SATURATE == MODE_SAT) ? max_val : '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          boundary_hit = 1'b1;
          count_nxt    = (SATURATE == MODE_SAT) ? '0 : max_val;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= boundary_hit;
      // Setting beats clearing when both happen in one cycle.
      if (boundary_hit) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
